// File: rtl/alu_multicycle_pkg.sv
// Shared definitions for the multi-cycle ALU: op-code constants, controller
// state encoding and the shift-amount width derivation.
package alu_multicycle_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADDU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } state_t;

  // Shift-amount width for a given datapath width.
  function automatic int shw_of(input int width);
    return $clog2(width);
  endfunction

  function automatic logic is_mul_op(input logic [3:0] code);
    return (code == OP_MULU) || (code == OP_MUL);
  endfunction

  function automatic logic is_div_op(input logic [3:0] code);
    return (code == OP_DIVU) || (code == OP_DIV);
  endfunction

  // Only the iterative ops have a signed/unsigned distinction that matters here.
  function automatic logic is_signed_op(input logic [3:0] code);
    return (code == OP_MUL) || (code == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / divide engine. Operates on operand magnitudes, one bit
// per cycle for WIDTH cycles, then applies the sign corrections. A shared
// 2*WIDTH accumulator holds {high acc, multiplier} or {remainder, quotient}.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  logic [CW-1:0]      cnt_r;
  logic               div_r;
  logic               neg_lo_r;
  logic               neg_hi_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH-1:0] acc_r;

  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_trial_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  // Operand magnitudes for signed requests.
  always_comb begin
    a_mag_s = a;
    b_mag_s = b;
    if (is_signed && a[WIDTH-1]) a_mag_s = -a;
    else                         a_mag_s = a;
    if (is_signed && b[WIDTH-1]) b_mag_s = -b;
    else                         b_mag_s = b;
  end

  // One shift-add or restoring-subtract step on the accumulator.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, opnd_r};
    if (!div_r)
      acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    else if (!div_trial_s[WIDTH])
      acc_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    else
      acc_next_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
  end

  // Load operands on request, then iterate until the counter saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r    <= CNT_LAST;
      div_r    <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      opnd_r   <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
    end else if (load) begin
      cnt_r    <= {CW{1'b0}};
      div_r    <= is_div;
      neg_lo_r <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_r <= is_signed & a[WIDTH-1];
      opnd_r   <= is_div ? b_mag_s : a_mag_s;
      acc_r    <= {{WIDTH{1'b0}}, (is_div ? a_mag_s : b_mag_s)};
    end else if (cnt_r != CNT_LAST) begin
      cnt_r <= cnt_r + CW'(1);
      acc_r <= acc_next_s;
    end else begin
      cnt_r <= cnt_r;
      acc_r <= acc_r;
    end
  end

  // Sign correction: product sign a^b; quotient a^b, remainder follows a.
  always_comb begin
    prod_s = neg_lo_r ? -acc_r : acc_r;
    quo_s  = neg_lo_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_s  = neg_hi_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    if (div_r) begin
      res_lo = quo_s;
      res_hi = rem_s;
    end else begin
      res_lo = prod_s[WIDTH-1:0];
      res_hi = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  assign fin = (cnt_r == CNT_LAST);

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU top: request capture, single-cycle ops, controller FSM and
// registered result/flag outputs. Multiply/divide run in alu_muldiv_iter.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_hi,
  output logic             z,
  output logic             ovf,
  output logic             dz
);

  localparam int SHW = shw_of(WIDTH);

  state_t           state_r;
  state_t           next_state_s;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             pend_r;
  logic             done_r;
  logic [WIDTH-1:0] c_r;
  logic [WIDTH-1:0] c_hi_r;
  logic             z_r;
  logic             ovf_r;
  logic             dz_r;

  logic             accept_s;
  logic             load_s;
  logic             fin_s;
  logic             iter_done_s;
  logic [WIDTH-1:0] it_lo_s;
  logic [WIDTH-1:0] it_hi_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] sc_c_s;
  logic             sc_ovf_s;
  logic             res_valid_s;
  logic [WIDTH-1:0] res_c_s;
  logic [WIDTH-1:0] res_hi_s;
  logic             res_ovf_s;
  logic             res_dz_s;

  assign ready       = (state_r == IDLE);
  assign accept_s    = start & ready;
  assign load_s      = accept_s & (is_mul_op(op) | is_div_op(op));
  assign iter_done_s = (state_r != IDLE) & fin_s;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .is_div    (is_div_op(op)),
    .is_signed (is_signed_op(op)),
    .a         (a),
    .b         (b),
    .fin       (fin_s),
    .res_lo    (it_lo_s),
    .res_hi    (it_hi_s)
  );

  // Controller next state: single-cycle ops never leave IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_s) next_state_s = is_div_op(op) ? DIV : MUL;
        else        next_state_s = IDLE;
      end
      MUL, DIV: begin
        if (fin_s) next_state_s = IDLE;
        else       next_state_s = state_r;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // Capture the accepted request; later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r   <= 4'b0000;
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      pend_r <= 1'b0;
    end else if (accept_s) begin
      op_r   <= op;
      a_r    <= a;
      b_r    <= b;
      pend_r <= ~load_s;
    end else begin
      op_r   <= op_r;
      a_r    <= a_r;
      b_r    <= b_r;
      pend_r <= 1'b0;
    end
  end

  // Single-cycle ops evaluated from the captured request.
  always_comb begin
    shamt_s  = a_r[SHW-1:0];
    sum_s    = a_r + b_r;
    diff_s   = a_r - b_r;
    sc_c_s   = {WIDTH{1'b0}};
    sc_ovf_s = 1'b0;
    case (op_r)
      OP_ADD: begin
        sc_c_s   = sum_s;
        sc_ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        sc_c_s   = diff_s;
        sc_ovf_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_ADDU: sc_c_s = sum_s;
      OP_AND:  sc_c_s = a_r & b_r;
      OP_OR:   sc_c_s = a_r | b_r;
      OP_SLTU: sc_c_s = {{(WIDTH-1){1'b0}}, (a_r < b_r)};
      OP_SLT:  sc_c_s = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
      OP_SLL:  sc_c_s = b_r << shamt_s;
      OP_SRL:  sc_c_s = b_r >> shamt_s;
      default: sc_c_s = {WIDTH{1'b0}};
    endcase
  end

  // Pick the completing result; a zero divisor overrides the iterator.
  always_comb begin
    res_valid_s = iter_done_s | pend_r;
    res_c_s     = c_r;
    res_hi_s    = c_hi_r;
    res_ovf_s   = ovf_r;
    res_dz_s    = dz_r;
    if (iter_done_s) begin
      res_ovf_s = 1'b0;
      if (is_div_op(op_r) && (b_r == {WIDTH{1'b0}})) begin
        res_c_s  = {WIDTH{1'b1}};
        res_hi_s = a_r;
        res_dz_s = 1'b1;
      end else begin
        res_c_s  = it_lo_s;
        res_hi_s = it_hi_s;
        res_dz_s = 1'b0;
      end
    end else if (pend_r) begin
      res_c_s   = sc_c_s;
      res_hi_s  = {WIDTH{1'b0}};
      res_ovf_s = sc_ovf_s;
      res_dz_s  = 1'b0;
    end else begin
      res_valid_s = 1'b0;
    end
  end

  // Result registers update only on completion and hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_r <= 1'b0;
      c_r    <= {WIDTH{1'b0}};
      c_hi_r <= {WIDTH{1'b0}};
      z_r    <= 1'b0;
      ovf_r  <= 1'b0;
      dz_r   <= 1'b0;
    end else if (res_valid_s) begin
      done_r <= 1'b1;
      c_r    <= res_c_s;
      c_hi_r <= res_hi_s;
      z_r    <= (res_c_s == {WIDTH{1'b0}});
      ovf_r  <= res_ovf_s;
      dz_r   <= res_dz_s;
    end else begin
      done_r <= 1'b0;
      c_r    <= c_r;
      c_hi_r <= c_hi_r;
      z_r    <= z_r;
      ovf_r  <= ovf_r;
      dz_r   <= dz_r;
    end
  end

  assign done = done_r;
  assign c    = c_r;
  assign c_hi = c_hi_r;
  assign z    = z_r;
  assign ovf  = ovf_r;
  assign dz   = dz_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle (WIDTH=32) with an arithmetic
// reference model and a per-cycle compare of done/ready/results.
module tb_alu_multicycle;

  localparam int WIDTH = 32;
  localparam int NV = 21;

  typedef struct packed {
    logic [31:0] c;
    logic [31:0] c_hi;
    logic        z;
    logic        ovf;
    logic        dz;
  } res_t;

  typedef struct packed {
    logic [31:0] due;
    res_t        r;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [31:0] c;
  logic [31:0] c_hi;
  logic        z;
  logic        ovf;
  logic        dz;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   busy_until = 0;
  int   base;
  exp_t q[$];
  res_t last = '0;

  logic [3:0]  v_op [NV] = '{4'b0100, 4'b0110, 4'b0010, 4'b0000, 4'b0001, 4'b0011, 4'b1100,
                             4'b0111, 4'b0101, 4'b0110, 4'b1101, 4'b1000, 4'b1001, 4'b1010,
                             4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1001, 4'b1011, 4'b0100};
  logic [31:0] v_a  [NV] = '{32'h7FFFFFFF, 32'd9, 32'h24, 32'hF0F01234, 32'hF0F00000, 32'd1,
                             32'd1, 32'hFFFFFFE3, 32'hFFFFFFFF, 32'h80000000, 32'd5,
                             32'hFFFFFFFF, 32'hFFFFFFFD, 32'd100, 32'hFFFFFFF9, 32'd5,
                             32'h80000000, 32'd7, 32'h80000000, 32'hFFFFFFF9, 32'd1};
  logic [31:0] v_b  [NV] = '{32'd1, 32'd9, 32'd1, 32'h0FF0FFFF, 32'h00001234, 32'hFFFFFFFF,
                             32'hFFFFFFFF, 32'h80000000, 32'd2, 32'd1, 32'd5, 32'd2, 32'd5,
                             32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000,
                             32'd0, 32'd2};

  alu_multicycle #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .c     (c),
    .c_hi  (c_hi),
    .z     (z),
    .ovf   (ovf),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // Reference result computed with plain wide arithmetic.
  function automatic res_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    longint      sx;
    longint      sy;
    logic [63:0] w;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    case (o)
      4'b0100: begin w = sx + sy; r.c = w[31:0]; r.ovf = (w[63:31] != {33{w[31]}}); end
      4'b0110: begin w = sx - sy; r.c = w[31:0]; r.ovf = (w[63:31] != {33{w[31]}}); end
      4'b0101: r.c = x + y;
      4'b0000: r.c = x & y;
      4'b0001: r.c = x | y;
      4'b0011: r.c = (x < y) ? 32'd1 : 32'd0;
      4'b1100: r.c = (sx < sy) ? 32'd1 : 32'd0;
      4'b0010: r.c = y << x[4:0];
      4'b0111: r.c = y >> x[4:0];
      4'b1000: begin w = {32'd0, x} * {32'd0, y}; r.c = w[31:0]; r.c_hi = w[63:32]; end
      4'b1001: begin w = sx * sy; r.c = w[31:0]; r.c_hi = w[63:32]; end
      4'b1010, 4'b1011: begin
        if (y == 32'd0) begin
          r.c = 32'hFFFFFFFF; r.c_hi = x; r.dz = 1'b1;
        end else if (o == 4'b1010) begin
          r.c = x / y; r.c_hi = x % y;
        end else begin
          w = sx / sy; r.c = w[31:0];
          w = sx % sy; r.c_hi = w[31:0];
        end
      end
      default: r = '0;
    endcase
    r.z = (r.c == 32'd0);
    return r;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle compare of done, ready and the held/updated outputs.
  always @(negedge clk) begin
    res_t got;
    logic exp_done;
    logic exp_ready;
    got = {c, c_hi, z, ovf, dz};
    if (!rst_n) begin
      q.delete();
      last = '0;
      busy_until = 0;
      check($sformatf("reset_cyc%0d", cyc), {3'b0, done, ready, got}, {3'b0, 1'b0, 1'b1, 67'b0});
    end else begin
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      if (exp_done) begin
        last = q[0].r;
        void'(q.pop_front());
      end
      exp_ready = (cyc >= busy_until);
      check($sformatf("cyc%0d", cyc), {3'b0, done, ready, got}, {3'b0, exp_done, exp_ready, last});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present a request for one cycle; the model decides whether it is accepted.
  task automatic req(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   lat;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (cyc >= busy_until) begin
      lat   = (o >= 4'b1000 && o <= 4'b1011) ? WIDTH + 1 : 1;
      e.due = cyc + 1 + lat;
      e.r   = model(o, x, y);
      q.push_back(e);
      if (lat > 1) busy_until = cyc + 1 + lat;
    end
    step();
  endtask

  // Idle (with scrambled inputs) until a new request would be accepted.
  task automatic wait_ready();
    start = 1'b0;
    while (cyc < busy_until) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = $urandom;
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 4'b0000;
    a     = 32'd0;
    b     = 32'd0;

    check("pin_add_ovf", model(4'b0100, 32'h7FFFFFFF, 32'd1), {32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0});
    check("pin_mulu",    model(4'b1000, 32'hFFFFFFFF, 32'd2), {32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 1'b0});
    check("pin_mul",     model(4'b1001, 32'hFFFFFFFD, 32'd5), {32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
    check("pin_divu",    model(4'b1010, 32'd100, 32'd7), {32'd14, 32'd2, 1'b0, 1'b0, 1'b0});
    check("pin_div",     model(4'b1011, 32'hFFFFFFF9, 32'd2), {32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
    check("pin_dz",      model(4'b1010, 32'd5, 32'd0), {32'hFFFFFFFF, 32'd5, 1'b0, 1'b0, 1'b1});
    check("pin_sll",     model(4'b0010, 32'h24, 32'd1), {32'd16, 32'h0, 1'b0, 1'b0, 1'b0});
    check("pin_sub_z",   model(4'b0110, 32'd9, 32'd9), {32'd0, 32'h0, 1'b1, 1'b0, 1'b0});

    repeat (3) step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      wait_ready();
      req(v_op[i], v_a[i], v_b[i]);
    end

    // Busy-time start is ignored; a start in the done cycle is accepted.
    wait_ready();
    req(4'b1000, 32'h12345678, 32'h9ABCDEF0);
    base  = done_cnt;
    start = 1'b0;
    repeat (3) step();
    req(4'b0000, 32'hFF, 32'hFF);
    wait_ready();
    check("single_done", 72'(done_cnt - base), 72'd1);
    req(4'b0011, 32'd3, 32'd4);

    // Reset in the middle of a divide aborts it without a done pulse.
    wait_ready();
    req(4'b1010, 32'd1000, 32'd3);
    start = 1'b0;
    repeat (8) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    req(4'b0001, 32'hA0, 32'h0B);

    start = 1'b0;
    for (int i = 0; i < 200 && q.size() > 0; i++) step();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected 0", q.size());
    end
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits, legal values 8..64.
REQ-002 SHALL have derived constant SHW = clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: synchronous and active-low.
REQ-005 SHALL have port start, input, 1, operation request; sampled only when ready=1.
REQ-006 SHALL have port op, input, 4, operation code (REQ-013).
REQ-007 SHALL have ports a and b, input, WIDTH each, operands.
REQ-008 SHALL have port ready, output, 1, high when a start will be accepted.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have ports c and c_hi, output, WIDTH each: c = primary result, c_hi = product high half or remainder.
REQ-011 SHALL have ports z, ovf and dz, output, 1 each: zero, signed overflow and divide-by-zero flags.

Function
REQ-012 SHALL capture op, a and b into internal registers on the clk edge where start=1 and ready=1; input changes after capture SHALL NOT affect the result.
REQ-013 SHALL implement these op codes:
- 0100 signed add; 0110 signed sub; 0101 unsigned add
- 0000 AND; 0001 OR; 0011 unsigned a<b -> 1 else 0
- 0010 b << a[SHW-1:0]; 0111 b >> a[SHW-1:0] (logical)
- 1000 MULU; 1001 MUL signed; 1010 DIVU; 1011 DIV signed; 1100 signed a<b
- 1101..1111 reserved: result 0, completes as single-cycle.
REQ-014 SHALL use FSM states IDLE, MUL, DIV; ready = (state==IDLE).
REQ-015 Single-cycle ops SHALL complete with done=1, outputs valid, on the edge after acceptance (latency 1); state stays IDLE.
REQ-016 MUL ops SHALL run an iterative shift-add, one bit per cycle, for WIDTH cycles; done follows at latency WIDTH+1.
REQ-017 MUL signed SHALL multiply magnitudes and negate the 2*WIDTH product when operand signs differ.
REQ-018 DIV ops SHALL run a restoring divide for WIDTH cycles (latency WIDTH+1); signed quotient takes sign a^b, remainder takes sign of a.
REQ-019 MUL SHALL deliver product low half on c and high half on c_hi; DIV SHALL deliver quotient on c and remainder on c_hi; other ops SHALL drive c_hi=0.
REQ-020 Divide by zero SHALL complete at normal latency with c = all ones, c_hi = a, dz=1; otherwise dz=0.
REQ-021 ovf SHALL be 1 only for ops 0100/0110 on signed overflow; it is 0 for all other ops.
REQ-022 z SHALL equal (c==0), registered with c.
REQ-023 c, c_hi, z, ovf and dz SHALL hold their values until the next completion.
REQ-024 start while ready=0 SHALL be ignored: no queuing, no effect on the running op.
REQ-025 done is registered and asserted while state==IDLE, so a start in the done cycle SHALL be accepted, giving back-to-back operation.
REQ-026 Shift amounts SHALL use only a[SHW-1:0]; upper bits of a are ignored.

Reset
REQ-027 When rst_n=0 at a clk edge: state->IDLE, done=0, and c, c_hi, z, ovf, dz -> 0.
REQ-028 Reset asserted mid-MUL or mid-DIV SHALL abort the op with no done pulse; ready=1 on the first edge after rst_n returns high.

Structure
REQ-029 A shared package SHALL hold the op-code constants, the FSM state encoding and the SHW derivation.
REQ-030 Multiply/divide iteration SHALL live in one sub-module, alu_muldiv_iter; single-cycle ops and the FSM SHALL stay in the top level.

Verification (WIDTH=32)
REQ-031 op=0100, a=0x7FFFFFFF, b=1 -> next cycle done=1, c=0x80000000, ovf=1, z=0.
REQ-032 op=1000, a=0xFFFFFFFF, b=2 -> done 33 cycles after accept, c=0xFFFFFFFE, c_hi=1; op=1001, a=-3, b=5 -> c=0xFFFFFFF1, c_hi=0xFFFFFFFF.
REQ-033 op=1010, a=100, b=7 -> c=14, c_hi=2, dz=0; op=1011, a=-7, b=2 -> c=-3, c_hi=-1; op=1010, a=5, b=0 -> c=0xFFFFFFFF, c_hi=5, dz=1.
REQ-034 op=0010, a=0x24, b=1 -> c=16; op=0110, a=b=9 -> c=0, z=1.
REQ-035 Start MULU, pulse start with op=0000 at cycle 5 -> second request ignored, single done at cycle 33 with the MUL result; a start in the done cycle is accepted.
REQ-036 rst_n=0 at cycle 10 of a DIV -> no done, all outputs 0, ready=1 after release.
